// File: rtl/arbiter_pkg.sv
// Shared constants, FSM encoding and bus-unpack helper for the write-port arbiter.
package arbiter_pkg;

    localparam logic MODE_SP  = 1'b0;
    localparam logic MODE_WRR = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int unsigned FIELD_MAX_W = 8;
    localparam int unsigned BUS_MAX_W   = 256;

    // Extract field idx of width w from a packed per-port bus.
    function automatic logic [FIELD_MAX_W-1:0] unpack_field(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [BUS_MAX_W-1:0]   shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = FIELD_MAX_W'((BUS_MAX_W'(1) << w) - BUS_MAX_W'(1));
        return FIELD_MAX_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/arbiter_core_wrr_rr_pick.sv
// Rotating first-one finder: first set bit of mask at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] mask,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_PORTS);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arbiter_core_wrr.sv
// Per-packet write-port arbiter: strict priority or credit-based weighted round robin,
// grant held until the granted port signals done.
module arbiter_core_wrr
    import arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 16,
    parameter int unsigned PRI_W     = 3,
    parameter int unsigned WGT_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sp0_wrr1,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS*PRI_W-1:0] priority_in,
    input  logic [NUM_PORTS*WGT_W-1:0] weight_in,
    input  logic                       done,
    output logic                       grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0] grant_port,
    output logic [NUM_PORTS-1:0]       grant_onehot
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    state_t               state, state_nxt;
    logic                 valid_nxt;
    logic [IDX_W-1:0]     port_nxt;
    logic [NUM_PORTS-1:0] onehot_nxt;

    logic [PRI_W-1:0]     pri        [NUM_PORTS];
    logic [WGT_W-1:0]     wgt_raw    [NUM_PORTS];
    logic [WGT_W-1:0]     wgt_load   [NUM_PORTS];
    logic [WGT_W-1:0]     credit     [NUM_PORTS];
    logic [WGT_W-1:0]     credit_cur [NUM_PORTS];
    logic [WGT_W-1:0]     credit_nxt [NUM_PORTS];

    logic [IDX_W-1:0]     ptr, ptr_nxt, scan_ptr;
    logic                 last_mode, last_mode_nxt;
    logic                 wrr_enter;
    logic [NUM_PORTS-1:0] pre_mask;
    logic                 pre_found, post_found;
    logic [IDX_W-1:0]     pre_idx, post_idx, win_idx;

    logic [IDX_W-1:0]     sp_idx;
    logic [PRI_W-1:0]     sp_best;
    logic                 sp_have;

    // Field unpack; entering WRR from SP arbitrates on freshly reloaded credits from port 0.
    always_comb begin
        wrr_enter = (sp0_wrr1 == MODE_WRR) && (last_mode == MODE_SP);
        scan_ptr  = wrr_enter ? '0 : ptr;
        pre_mask  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pri[i]        = PRI_W'(unpack_field(BUS_MAX_W'(priority_in), i, PRI_W));
            wgt_raw[i]    = WGT_W'(unpack_field(BUS_MAX_W'(weight_in), i, WGT_W));
            wgt_load[i]   = (wgt_raw[i] == '0) ? WGT_W'(1) : wgt_raw[i];
            credit_cur[i] = wrr_enter ? wgt_load[i] : credit[i];
            pre_mask[i]   = req[i] && (credit_cur[i] != '0);
        end
    end

    // Strict '>' keeps the lowest index on priority ties.
    always_comb begin
        sp_idx  = '0;
        sp_best = '0;
        sp_have = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && (!sp_have || pri[i] > sp_best)) begin
                sp_have = 1'b1;
                sp_best = pri[i];
                sp_idx  = IDX_W'(i);
            end
        end
    end

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_pre (
        .mask  (pre_mask),
        .ptr   (scan_ptr),
        .found (pre_found),
        .idx   (pre_idx)
    );

    // After a reload every requester has credit, so the raw request mask is eligible.
    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_post (
        .mask  (req),
        .ptr   (scan_ptr),
        .found (post_found),
        .idx   (post_idx)
    );

    always_comb begin
        state_nxt     = state;
        valid_nxt     = grant_valid;
        port_nxt      = grant_port;
        onehot_nxt    = grant_onehot;
        credit_nxt    = credit;
        ptr_nxt       = ptr;
        last_mode_nxt = last_mode;
        win_idx       = '0;
        unique case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    state_nxt     = ST_GRANT;
                    valid_nxt     = 1'b1;
                    last_mode_nxt = sp0_wrr1;
                    if (sp0_wrr1 == MODE_SP) begin
                        win_idx = sp_idx;
                    end else begin
                        if (pre_found) begin
                            win_idx    = pre_idx;
                            credit_nxt = credit_cur;
                        end else begin
                            win_idx    = post_idx;
                            credit_nxt = wgt_load;
                        end
                        if (credit_nxt[win_idx] != '0)
                            credit_nxt[win_idx] = credit_nxt[win_idx] - WGT_W'(1);
                        ptr_nxt = (credit_nxt[win_idx] == '0 || !post_found)
                                  ? IDX_W'((32'(win_idx) + 32'd1) % NUM_PORTS)
                                  : win_idx;
                    end
                    port_nxt   = win_idx;
                    onehot_nxt = NUM_PORTS'(1) << win_idx;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    state_nxt  = ST_IDLE;
                    valid_nxt  = 1'b0;
                    port_nxt   = '0;
                    onehot_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant_valid  <= 1'b0;
            grant_port   <= '0;
            grant_onehot <= '0;
            ptr          <= '0;
            last_mode    <= MODE_SP;
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                credit[i] <= '0;
        end else begin
            state        <= state_nxt;
            grant_valid  <= valid_nxt;
            grant_port   <= port_nxt;
            grant_onehot <= onehot_nxt;
            ptr          <= ptr_nxt;
            last_mode    <= last_mode_nxt;
            credit       <= credit_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_core_wrr.sv
// Self-checking bench for arbiter_core_wrr: directed scenarios plus randomized packets
// compared against a behavioural SP/WRR model.
module tb_arbiter_core_wrr;

    localparam int N     = 16;
    localparam int PRI_W = 3;
    localparam int WGT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sp0_wrr1 = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*PRI_W-1:0] priority_in = '0;
    logic [N*WGT_W-1:0] weight_in = '0;
    logic             done = 1'b0;
    logic             grant_valid;
    logic [3:0]       grant_port;
    logic [N-1:0]     grant_onehot;

    int checks = 0;
    int errors = 0;

    int m_credit [N];
    int m_ptr;
    int m_last_mode;

    arbiter_core_wrr #(.NUM_PORTS(N), .PRI_W(PRI_W), .WGT_W(WGT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sp0_wrr1     (sp0_wrr1),
        .req          (req),
        .priority_in  (priority_in),
        .weight_in    (weight_in),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_port   (grant_port),
        .grant_onehot (grant_onehot)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pri_of(input int i);
        return int'(priority_in[i*PRI_W +: PRI_W]);
    endfunction

    function automatic int wgt_of(input int i);
        int w;
        w = int'(weight_in[i*WGT_W +: WGT_W]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic set_pri(input int i, input int v);
        priority_in[i*PRI_W +: PRI_W] = PRI_W'(v);
    endtask

    task automatic set_wgt(input int i, input int v);
        weight_in[i*WGT_W +: WGT_W] = WGT_W'(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = 0;
        m_ptr       = 0;
        m_last_mode = 0;
    endtask

    task automatic model_reload();
        for (int i = 0; i < N; i++) m_credit[i] = wgt_of(i);
    endtask

    // Winner for the current inputs, updating credits/pointer as a grant would.
    task automatic model_arb(output int win);
        win = -1;
        if (sp0_wrr1 == 1'b0) begin
            for (int i = 0; i < N; i++)
                if (req[i] && (win < 0 || pri_of(i) > pri_of(win))) win = i;
            m_last_mode = 0;
        end else begin
            if (m_last_mode == 0) begin
                model_reload();
                m_ptr = 0;
            end
            for (int pass = 0; pass < 2 && win < 0; pass++) begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (win < 0 && req[p] && m_credit[p] > 0) win = p;
                end
                if (win < 0) model_reload();
            end
            m_credit[win] = m_credit[win] - 1;
            m_ptr = (m_credit[win] == 0) ? (win + 1) % N : win;
            m_last_mode = 1;
        end
    endtask

    task automatic arb(input string tag, output int win);
        model_arb(win);
        step();
        check_eq({tag, "_valid"}, 32'(grant_valid), 32'd1);
        check_eq({tag, "_port"}, 32'(grant_port), 32'(win));
        check_eq({tag, "_onehot"}, 32'(grant_onehot), 32'd1 << win);
    endtask

    task automatic hold_release(input string tag, input int cycles, input bit perturb, input int port);
        for (int c = 0; c < cycles; c++) begin
            if (perturb) begin
                req         = N'($urandom);
                priority_in = (N*PRI_W)'({$urandom, $urandom});
                sp0_wrr1    = 1'($urandom);
            end
            step();
            check_eq({tag, "_hold_valid"}, 32'(grant_valid), 32'd1);
            check_eq({tag, "_hold_port"}, 32'(grant_port), 32'(port));
        end
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq({tag, "_rel_valid"}, 32'(grant_valid), 32'd0);
        check_eq({tag, "_rel_onehot"}, 32'(grant_onehot), 32'd0);
    endtask

    initial begin
        int w;
        int wrr_seq [9] = '{0, 0, 1, 2, 2, 2, 0, 0, 1};
        int wrap_seq [4] = '{15, 0, 15, 0};

        model_reset();
        step();
        check_eq("rst_valid", 32'(grant_valid), 32'd0);
        check_eq("rst_port", 32'(grant_port), 32'd0);
        check_eq("rst_onehot", 32'(grant_onehot), 32'd0);
        rst = 1'b0;

        // SP tie between ports 1 and 2, then a lone priority-0 requester
        sp0_wrr1 = 1'b0;
        set_pri(1, 5);
        set_pri(2, 5);
        req = 16'h0006;
        arb("sp_tie", w);
        check_eq("sp_tie_const", 32'(grant_port), 32'd1);
        hold_release("sp_tie", 1, 1'b0, w);
        req = 16'h0001;
        set_pri(0, 0);
        arb("sp_p0", w);
        check_eq("sp_p0_const", 32'(grant_port), 32'd0);
        hold_release("sp_p0", 0, 1'b0, w);

        // Grant held while inputs move; next arbitration enters WRR from port 0
        req = 16'h0004;
        set_pri(2, 1);
        arb("hold", w);
        req = 16'h0008;
        set_pri(3, 7);
        sp0_wrr1 = 1'b1;
        set_wgt(3, 2);
        hold_release("hold", 3, 1'b0, 2);
        arb("hold_next", w);
        check_eq("hold_next_const", 32'(grant_port), 32'd3);
        hold_release("hold_next", 1, 1'b0, w);

        // Stray done in IDLE has no effect
        req  = '0;
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("stray_valid", 32'(grant_valid), 32'd0);
        req = 16'h0020;
        arb("stray_next", w);
        hold_release("stray_next", 0, 1'b0, w);

        // Asynchronous reset during an SP grant
        sp0_wrr1 = 1'b0;
        req = 16'h0008;
        arb("rst_mid", w);
        check_eq("rst_mid_const", 32'(grant_port), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(grant_valid), 32'd0);
        check_eq("rst_mid_port", 32'(grant_port), 32'd0);
        check_eq("rst_mid_onehot", 32'(grant_onehot), 32'd0);
        model_reset();
        step();
        check_eq("rst_held_valid", 32'(grant_valid), 32'd0);

        // WRR weights 2,1,3 after reset
        weight_in = '0;
        set_wgt(0, 2);
        set_wgt(1, 1);
        set_wgt(2, 3);
        sp0_wrr1 = 1'b1;
        req = 16'h0007;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            arb("wrr_w", w);
            check_eq("wrr_w_seq", 32'(grant_port), 32'(wrr_seq[i]));
            hold_release("wrr_w", 0, 1'b0, w);
        end

        // Reload and wrap across port 15 -> 0
        weight_in = '0;
        set_wgt(0, 1);
        set_wgt(14, 1);
        set_wgt(15, 1);
        sp0_wrr1 = 1'b0;
        req = 16'h0001;
        arb("wrap_sp", w);
        hold_release("wrap_sp", 0, 1'b0, w);
        sp0_wrr1 = 1'b1;
        req = 16'h4000;
        arb("wrap_pre", w);
        check_eq("wrap_pre_const", 32'(grant_port), 32'd14);
        hold_release("wrap_pre", 0, 1'b0, w);
        req = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            arb("wrap", w);
            check_eq("wrap_seq", 32'(grant_port), 32'(wrap_seq[i]));
            hold_release("wrap", 0, 1'b0, w);
        end

        // Randomized packets against the model
        for (int it = 0; it < 300; it++) begin
            sp0_wrr1    = 1'($urandom);
            req         = N'($urandom);
            if ($urandom_range(1, 0) == 1) req = req & N'($urandom) & N'($urandom);
            if (req == '0) req = N'(1) << $urandom_range(N-1, 0);
            priority_in = (N*PRI_W)'({$urandom, $urandom});
            if ($urandom_range(3, 0) == 0)
                weight_in = (N*WGT_W)'({$urandom, $urandom});
            arb("rand", w);
            hold_release("rand", $urandom_range(3, 0), 1'b1, w);
            if ($urandom_range(3, 0) == 0) begin
                req  = '0;
                done = 1'($urandom);
                step();
                done = 1'b0;
                check_eq("rand_idle_valid", 32'(grant_valid), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
